deserializer_1to64_serdes: RTL and testbench

- Receive-side counterpart of the 64-to-1 serializer: accepts the MSB-first serial bitstream plus its bit-valid strobe and reassembles WIDTH-bit parallel words.
- Presents completed words on a valid/ready output handshake with a one-word holding register.
- Sits at the far end of the serial link in the same clk_serial domain, feeding downstream parallel logic.
- Flags words lost to downstream backpressure.

---
 rtl/deserializer_1to64_serdes.sv | 127 ++++++++++++
 tb/tb_deserializer_1to64_serdes.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/deserializer_1to64_serdes.sv
`default_nettype none
// ============================================================================
// Module      : deserializer_1to64_serdes
// Description : Serial-to-parallel receiver. Collects a bit-valid-qualified
//               serial stream into WIDTH-bit words and hands each completed
//               word to downstream logic via a valid/ready holding register.
//               Words that complete while the holding register is still
//               occupied (and not being drained that cycle) are dropped and
//               flagged on a sticky overflow bit.
// Revision    : 1.0 - initial release
// ============================================================================
module deserializer_1to64_serdes #(
  parameter int WIDTH     = 64,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_serial,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             sync_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             busy,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_zero = '0;

  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overflow;

  logic [WIDTH-1:0] w_shift_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_take_bit;
  logic             w_word_done;
  logic             w_loadable;
  logic             w_consume;

  // A bit is taken only when realign is not requested; realign wins.
  assign w_take_bit  = serial_valid && !sync_clr;
  assign w_word_done = w_take_bit && (r_bit_cnt == c_cnt_last);
  assign w_consume   = r_valid && ready_in;
  // The holding register can accept a new word if empty or draining now.
  assign w_loadable  = !r_valid || ready_in;

  // The shift direction decides where the first received bit ends up; the
  // completed word is the shifted value including the current bit.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shift_next = {r_shift[WIDTH-2:0], serial_in};
    end else begin : g_lsb_first
      assign w_shift_next = {serial_in, r_shift[WIDTH-1:1]};
    end
  endgenerate

  // Next bit count: clear on realign, advance on a valid bit, wrap at the end.
  always_comb begin
    w_cnt_next = r_bit_cnt;
    if (sync_clr) begin
      w_cnt_next = c_cnt_zero;
    end else if (serial_valid) begin
      if (r_bit_cnt == c_cnt_last) begin
        w_cnt_next = c_cnt_zero;
      end else begin
        w_cnt_next = r_bit_cnt + c_cnt_one;
      end
    end
  end

  // Shift register and bit counter; busy tracks the counter's next value so
  // that it always equals (bit_cnt != 0) as seen from outside.
  always_ff @(posedge clk_serial) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= c_cnt_zero;
      r_busy    <= 1'b0;
    end else begin
      if (sync_clr) begin
        r_shift <= '0;
      end else if (serial_valid) begin
        r_shift <= w_shift_next;
      end
      r_bit_cnt <= w_cnt_next;
      r_busy    <= (w_cnt_next != c_cnt_zero);
    end
  end

  // Output holding register: load a completed word when there is room,
  // otherwise release the current word once downstream accepts it.
  always_ff @(posedge clk_serial) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_word_done && w_loadable) begin
      r_data  <= w_shift_next;
      r_valid <= 1'b1;
    end else if (w_consume) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky drop flag, cleared only by reset or realign.
  always_ff @(posedge clk_serial) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (sync_clr) begin
      r_overflow <= 1'b0;
    end else if (w_word_done && !w_loadable) begin
      r_overflow <= 1'b1;
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign busy      = r_busy;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_deserializer_1to64_serdes.sv
`default_nettype none
// ============================================================================
// Module      : tb_deserializer_1to64_serdes
// Description : Scoreboard bench for deserializer_1to64_serdes. Drives one
//               serial stream into an MSB-first and an LSB-first instance and
//               checks delivered words against a bit-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deserializer_1to64_serdes;

  localparam int WIDTH = 64;

  logic             clk_serial = 1'b0;
  logic             rst = 1'b0;
  logic             serial_in = 1'b0;
  logic             serial_valid = 1'b0;
  logic             sync_clr = 1'b0;
  logic             ready_in = 1'b0;
  logic [WIDTH-1:0] data_msb, data_lsb;
  logic             valid_msb, valid_lsb;
  logic             busy_msb, busy_lsb;
  logic             ovf_msb, ovf_lsb;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic             bitq[$];
  logic             m_valid = 1'b0;
  logic             m_ovf = 1'b0;
  logic [WIDTH-1:0] m_dmsb = '0;
  logic [WIDTH-1:0] m_dlsb = '0;
  logic [WIDTH-1:0] exp_msb[$];
  logic [WIDTH-1:0] exp_lsb[$];

  deserializer_1to64_serdes #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
    .clk_serial(clk_serial), .rst(rst), .serial_in(serial_in),
    .serial_valid(serial_valid), .sync_clr(sync_clr), .data_out(data_msb),
    .valid_out(valid_msb), .ready_in(ready_in), .busy(busy_msb),
    .overflow(ovf_msb)
  );

  deserializer_1to64_serdes #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_serial(clk_serial), .rst(rst), .serial_in(serial_in),
    .serial_valid(serial_valid), .sync_clr(sync_clr), .data_out(data_lsb),
    .valid_out(valid_lsb), .ready_in(ready_in), .busy(busy_lsb),
    .overflow(ovf_lsb)
  );

  always #5 clk_serial = ~clk_serial;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: a handshake completes at the next rising edge.
  always @(negedge clk_serial) begin
    if (!rst && valid_msb && ready_in) begin
      if (exp_msb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL deliver_msb unexpected word actual=%h required=none", data_msb);
      end else begin
        check("deliver_msb", data_msb, exp_msb.pop_front());
      end
    end
    if (!rst && valid_lsb && ready_in) begin
      if (exp_lsb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL deliver_lsb unexpected word actual=%h required=none", data_lsb);
      end else begin
        check("deliver_lsb", data_lsb, exp_lsb.pop_front());
      end
    end
  end

  // One clock cycle: apply inputs, advance the model, then compare status.
  task automatic step(input logic r, input logic sv, input logic si,
                      input logic rdy, input logic clr);
    logic [WIDTH-1:0] wm, wl;
    logic             loaded;
    rst = r; serial_valid = sv; serial_in = si; ready_in = rdy; sync_clr = clr;
    if (r) begin
      bitq.delete(); m_valid = 1'b0; m_ovf = 1'b0;
      m_dmsb = '0; m_dlsb = '0;
      exp_msb.delete(); exp_lsb.delete();
    end else begin
      loaded = 1'b0;
      if (clr) begin
        bitq.delete(); m_ovf = 1'b0;
      end else if (sv) begin
        bitq.push_back(si);
        if (bitq.size() == WIDTH) begin
          for (int i = 0; i < WIDTH; i++) begin
            wm[WIDTH-1-i] = bitq[i];
            wl[i]         = bitq[i];
          end
          bitq.delete();
          if (!m_valid || rdy) begin
            m_dmsb = wm; m_dlsb = wl; loaded = 1'b1;
            exp_msb.push_back(wm); exp_lsb.push_back(wl);
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
      if (loaded) m_valid = 1'b1;
      else if (m_valid && rdy) m_valid = 1'b0;
    end
    @(posedge clk_serial);
    #1;
    check("valid_msb", {63'd0, valid_msb}, {63'd0, m_valid});
    check("valid_lsb", {63'd0, valid_lsb}, {63'd0, m_valid});
    check("busy", {63'd0, busy_msb}, {63'd0, (bitq.size() != 0)});
    check("overflow", {63'd0, ovf_msb}, {63'd0, m_ovf});
    check("overflow_lsb", {63'd0, ovf_lsb}, {63'd0, m_ovf});
    if (m_valid) begin
      check("hold_msb", data_msb, m_dmsb);
      check("hold_lsb", data_lsb, m_dlsb);
    end
  endtask

  // Send a word in transmission order (w[63] first); optional gaps after
  // bit indices ga and gb; the last bit is sent with ready last_rdy.
  task automatic send_word(input logic [WIDTH-1:0] w, input int ga, input int gb,
                           input int glen, input logic rdy, input logic last_rdy);
    for (int i = 0; i < WIDTH; i++) begin
      step(1'b0, 1'b1, w[WIDTH-1-i], (i == WIDTH-1) ? last_rdy : rdy, 1'b0);
      if (i == ga || i == gb)
        for (int g = 0; g < glen; g++) step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    // Reset and reset-state checks
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_data", data_msb, '0);
    idle(2, 1'b1);

    // Single word, ready held high
    send_word(64'hAAAABBBB_12345678, -1, -1, 0, 1'b1, 1'b1);
    check("single_word", data_msb, 64'hAAAABBBB_12345678);
    idle(3, 1'b1);

    // Three words with gaps inside word 2
    send_word(64'hAAAABBBB_00000001, -1, -1, 0, 1'b1, 1'b1);
    send_word(64'hAAAABBBB_00000002, 9, 39, 5, 1'b1, 1'b1);
    send_word(64'hAAAABBBB_00000003, -1, -1, 0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Backpressure: A held, B dropped, then drain A
    send_word(64'h1111_2222_3333_4444, -1, -1, 0, 1'b0, 1'b0);
    send_word(64'h5555_6666_7777_8888, -1, -1, 0, 1'b0, 1'b0);
    check("bp_hold_a", data_msb, 64'h1111_2222_3333_4444);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);

    // Same-edge consume and load
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word(64'h0123_4567_89AB_CDEF, -1, -1, 0, 1'b0, 1'b0);
    send_word(64'hFEDC_BA98_7654_3210, -1, -1, 0, 1'b0, 1'b1);
    check("same_edge_word2", data_msb, 64'hFEDC_BA98_7654_3210);
    idle(2, 1'b0);
    idle(2, 1'b1);

    // Realign: junk bits, sync_clr together with a valid bit, then a word
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    send_word(64'hDEADBEEF_CAFEF00D, -1, -1, 0, 1'b1, 1'b1);
    check("realign_word", data_msb, 64'hDEADBEEF_CAFEF00D);
    idle(2, 1'b1);

    // Reset mid-word, then a clean word; LSB instance sees 1 then 63 zeros
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    send_word(64'h8000_0000_0000_0000, -1, -1, 0, 1'b1, 1'b1);
    check("lsb_first_one", data_lsb, 64'h0000_0000_0000_0001);
    check("msb_first_one", data_msb, 64'h8000_0000_0000_0000);
    idle(2, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 999) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 299) == 0));
    end

    // Drain and confirm every expected word was delivered
    idle(4, 1'b1);
    check("scoreboard_empty_msb", 64'(exp_msb.size()), 64'd0);
    check("scoreboard_empty_lsb", 64'(exp_lsb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
